// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory port bundle of the load/store unit.
// master = execute stage plus memory, slave = the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_address, mem_write_data, mem_read, mem_write
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word extract on loads and
// read-modify-write for byte/halfword stores against a word-wide memory port.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] aligned_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        fault_q;

  logic        accept_c;
  logic        fault_c;
  logic [31:0] req_aligned_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;
  logic [31:0] merge_c;

  assign accept_c      = bus.req_valid && bus.req_ready;
  assign req_aligned_c = {bus.req_addr[31:2], 2'b00};

  // Request legality, evaluated on the incoming request at the accepting edge
  always_comb begin
    fault_c = 1'b0;
    case (bus.req_funct3)
      3'b011, 3'b110, 3'b111: fault_c = 1'b1;
      default: ;
    endcase
    if (bus.req_write && bus.req_funct3[2])                   fault_c = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])      fault_c = 1'b1;
    if (bus.req_funct3 == 3'b010 && bus.req_addr[1:0] != 2'b00) fault_c = 1'b1;
    if (req_aligned_c > LAST_WORD)                            fault_c = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (fault_c)                                         state_nxt = RESP;
          else if (bus.req_write && bus.req_funct3 == 3'b010)  state_nxt = WRITE;
          else                                                 state_nxt = READ;
        end
      end
      READ:    state_nxt = write_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and the read word used by both loads and sub-word stores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q   <= 1'b0;
      funct3_q  <= 3'b000;
      aligned_q <= 32'h0;
      lane_q    <= 2'b00;
      wdata_q   <= 32'h0;
      word_q    <= 32'h0;
      fault_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        write_q   <= bus.req_write;
        funct3_q  <= bus.req_funct3;
        aligned_q <= req_aligned_c;
        lane_q    <= bus.req_addr[1:0];
        wdata_q   <= bus.req_wdata;
        fault_q   <= fault_c;
      end
      if (state == READ) word_q <= bus.mem_read_data;
    end
  end

  always_comb begin
    byte_c  = word_q[{lane_q, 3'b000} +: 8];
    half_c  = word_q[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_c = {24'h0, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'h0, half_c};
      default: load_c = word_q;
    endcase
    merge_c = word_q;
    case (funct3_q[1:0])
      2'b00:   merge_c[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   merge_c[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_c = wdata_q;
    endcase
  end

  always_comb begin
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_rdata     = 32'h0;
    bus.resp_fault     = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = 32'h0;
    bus.mem_write_data = 32'h0;
    case (state)
      IDLE: bus.req_ready = !reset;
      READ: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = aligned_q;
      end
      WRITE: begin
        bus.mem_write      = 1'b1;
        bus.mem_address    = aligned_q;
        bus.mem_write_data = merge_c;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_fault = fault_q;
        bus.resp_rdata = (write_q || fault_q) ? 32'h0 : load_c;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset abort,
// back-to-back requests, and random requests against a byte-level reference model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];

  always_comb begin
    bus.mem_read_data = {mem[bus.mem_address[7:0] + 8'd3], mem[bus.mem_address[7:0] + 8'd2],
                         mem[bus.mem_address[7:0] + 8'd1], mem[bus.mem_address[7:0]]};
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.mem_write) begin
      for (int i = 0; i < 4; i++) mem[bus.mem_address[7:0] + 8'(i)] <= bus.mem_write_data[8*i +: 8];
    end
  end

  int n_reads = 0, n_writes = 0, n_resp = 0, n_both = 0, n_misalign = 0;
  logic [31:0] last_waddr, last_wdata;

  always @(negedge clk) begin
    if (bus.mem_read) n_reads++;
    if (bus.mem_write) begin
      n_writes++;
      last_waddr = bus.mem_address;
      last_wdata = bus.mem_write_data;
    end
    if (bus.resp_valid) n_resp++;
    if (bus.mem_read && bus.mem_write) n_both++;
    if (bus.mem_address[1:0] != 2'b00) n_misalign++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Reference: byte-addressed memory semantics straight from the ISA-level rules
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdata, output logic fault,
                       output int lat, output int reads, output int writes);
    int size;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    fault = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3[2]) ||
            ((addr % 32'(size)) != 0) || ((addr & ~32'd3) > 32'd252);
    rdata = 32'h0; lat = 1; reads = 0; writes = 0;
    if (!fault) begin
      if (!wr) begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v |= 32'(ref_mem[addr[7:0] + 8'(i)]) << (8*i);
        if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8*size)) - 32'd1);
        rdata = v; lat = 2; reads = 1;
      end else begin
        for (int i = 0; i < size; i++) ref_mem[addr[7:0] + 8'(i)] = wd[8*i +: 8];
        writes = 1;
        reads  = (size < 4) ? 1 : 0;
        lat    = (size < 4) ? 3 : 2;
      end
    end
  endtask

  // Issue one request from a negedge with the unit idle; returns at a negedge, idle again
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic fault,
                        output int lat, output int reads, output int writes, output logic hs_ok);
    int r0, w0;
    bit seen;
    r0 = n_reads; w0 = n_writes;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    seen = 1'b0; lat = 0; hs_ok = 1'b1; rdata = 32'h0; fault = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.req_ready) hs_ok = 1'b0;
      if (bus.resp_valid) begin
        seen = 1'b1; lat = k + 1; rdata = bus.resp_rdata; fault = bus.resp_fault;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL resp_timeout: got=no response expected=response within 8 cycles");
    end
    @(negedge clk);
    if (!bus.req_ready || bus.resp_valid) hs_ok = 1'b0;
    reads = n_reads - r0; writes = n_writes - w0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wword;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] rdata, m_rdata, w10;
    logic fault, m_fault, hs_ok;
    int lat, reads, writes, m_lat, m_reads, m_writes;
    int w0, p0, bad;
    int acc[$];
    int respc[$];
    logic [31:0] rds[$];
    int rdy_bad;
    string nm;

    tbl[0]  = '{1'b1, 3'b010, 32'h10,  32'h11223344, 32'h0,        1'b0, 2, 0, 1, 32'h11223344};
    tbl[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h11223344, 1'b0, 2, 1, 0, 32'h0};
    tbl[2]  = '{1'b1, 3'b000, 32'h13,  32'h000000AB, 32'h0,        1'b0, 3, 1, 1, 32'hAB223344};
    tbl[3]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hAB223344, 1'b0, 2, 1, 0, 32'h0};
    tbl[4]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFAB, 1'b0, 2, 1, 0, 32'h0};
    tbl[5]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000AB, 1'b0, 2, 1, 0, 32'h0};
    tbl[6]  = '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFAB22, 1'b0, 2, 1, 0, 32'h0};
    tbl[7]  = '{1'b0, 3'b101, 32'h12,  32'h0,        32'h0000AB22, 1'b0, 2, 1, 0, 32'h0};
    tbl[8]  = '{1'b1, 3'b001, 32'h10,  32'h00008001, 32'h0,        1'b0, 3, 1, 1, 32'hAB228001};
    tbl[9]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hAB228001, 1'b0, 2, 1, 0, 32'h0};
    tbl[10] = '{1'b0, 3'b010, 32'h11,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[11] = '{1'b0, 3'b001, 32'h13,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[12] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[13] = '{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[14] = '{1'b1, 3'b100, 32'h10,  32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[15] = '{1'b1, 3'b010, 32'hFC,  32'hCAFEF00D, 32'h0,        1'b0, 2, 0, 1, 32'hCAFEF00D};
    tbl[16] = '{1'b0, 3'b010, 32'hFC,  32'h0,        32'hCAFEF00D, 1'b0, 2, 1, 0, 32'h0};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    reset = 1'b1; mem_clr = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'h0);
    check("reset ctl outputs", 32'({bus.resp_valid, bus.resp_fault, bus.mem_read, bus.mem_write}), 32'h0);
    @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0;
    #1;
    check("post-reset req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      model(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, m_rdata, m_fault, m_lat, m_reads, m_writes);
      do_req(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, rdata, fault, lat, reads, writes, hs_ok);
      nm = $sformatf("vec%0d", i);
      check({nm, " rdata"}, rdata, tbl[i].exp_rdata);
      check({nm, " fault"}, 32'(fault), 32'(tbl[i].exp_fault));
      check({nm, " latency"}, 32'(lat), 32'(tbl[i].exp_lat));
      check({nm, " mem_read pulses"}, 32'(reads), 32'(tbl[i].exp_rd));
      check({nm, " mem_write pulses"}, 32'(writes), 32'(tbl[i].exp_wr));
      check({nm, " ready handshake"}, 32'(hs_ok), 32'h1);
      if (tbl[i].exp_wr != 0) begin
        check({nm, " write addr"}, last_waddr, tbl[i].addr & ~32'd3);
        check({nm, " write data"}, last_wdata, tbl[i].exp_wword);
      end
    end

    // Reset during the READ cycle of an SB: the store must vanish
    w0 = n_writes; p0 = n_resp;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h00000055;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort req_ready", 32'(bus.req_ready), 32'h0);
    check("abort ctl outputs", 32'({bus.resp_valid, bus.resp_fault, bus.mem_read, bus.mem_write}), 32'h0);
    check("abort data outputs", bus.mem_address | bus.mem_write_data | bus.resp_rdata, 32'h0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort ready after reset", 32'(bus.req_ready), 32'h1);
    repeat (4) @(negedge clk);
    check("abort no mem_write", 32'(n_writes - w0), 32'h0);
    check("abort no resp", 32'(n_resp - p0), 32'h0);
    w10 = {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]};
    check("abort mem word 0x10", w10, 32'hAB228001);

    // Two queued loads with req_valid held high
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
    rdy_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (acc.size() == 1 && c > acc[0]) bus.req_addr = 32'hFC;
      if (acc.size() == 2 && c > acc[1]) bus.req_valid = 1'b0;
      if ((c == 1 || c == 2) && bus.req_ready) rdy_bad++;
      if (bus.resp_valid) begin
        respc.push_back(c);
        rds.push_back(bus.resp_rdata);
      end
      if (bus.req_valid && bus.req_ready) acc.push_back(c);
    end
    bus.req_valid = 1'b0;
    check("b2b accept count", 32'(acc.size()), 32'd2);
    check("b2b resp count", 32'(respc.size()), 32'd2);
    check("b2b first resp cycle", (respc.size() > 0) ? 32'(respc[0]) : 32'hFFFFFFFF, 32'd2);
    check("b2b second accept edge", (acc.size() > 1) ? 32'(acc[1]) : 32'hFFFFFFFF, 32'd3);
    check("b2b ready low while busy", 32'(rdy_bad), 32'h0);
    check("b2b rdata0", (rds.size() > 0) ? rds[0] : 32'hDEADBEEF, 32'hAB228001);
    check("b2b rdata1", (rds.size() > 1) ? rds[1] : 32'hDEADBEEF, 32'hCAFEF00D);
    @(negedge clk);

    // Random requests against the reference model
    for (int n = 0; n < 250; n++) begin
      logic r_wr;
      logic [2:0] r_f3;
      logic [31:0] r_addr, r_wd;
      r_wr = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 271));
      r_wd = $urandom;
      model(r_wr, r_f3, r_addr, r_wd, m_rdata, m_fault, m_lat, m_reads, m_writes);
      do_req(r_wr, r_f3, r_addr, r_wd, rdata, fault, lat, reads, writes, hs_ok);
      nm = $sformatf("rnd%0d wr=%0d f3=%0d addr=0x%08h", n, r_wr, r_f3, r_addr);
      check({nm, " rdata"}, rdata, m_rdata);
      check({nm, " fault"}, 32'(fault), 32'(m_fault));
      check({nm, " latency"}, 32'(lat), 32'(m_lat));
      check({nm, " reads"}, 32'(reads), 32'(m_reads));
      check({nm, " writes"}, 32'(writes), 32'(m_writes));
      check({nm, " handshake"}, 32'(hs_ok), 32'h1);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("memory image bytes differing", 32'(bad), 32'h0);
    check("read and write both high", 32'(n_both), 32'h0);
    check("unaligned mem_address", 32'(n_misalign), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
